rr_slice_scheduler: RTL

RR_SLICE_SCHEDULER -- requirements
Module: rr_slice_scheduler

---
 rtl/rr_slice_scheduler.sv | 73 +++++++
 1 files changed

// File: rtl/rr_slice_scheduler.sv
// Round-robin arbiter over 4 requesters with time-sliced grants; grant registered on the request edge.
// Holder keeps the grant for SLICE cycles or until it drops req; rearbitration has no bubble cycle.
module rr_slice_scheduler #(
  parameter int SLICE = 4
) (
  input  logic       c,
  input  logic       r,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_vld,
  output logic       slice_end
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [3:0] CNT_INIT = 4'(SLICE - 1);

  state_t     state;
  logic [1:0] ptr;
  logic [3:0] cnt;

  logic       rearb;
  logic [1:0] base;
  logic [1:0] idx;
  logic [1:0] pick;
  logic       found;

  // Scan from lowest priority (base itself) up to base+1 so the last hit wins.
  always_comb begin
    rearb = (state == IDLE) || (cnt == 4'd0) || !req[gnt_id];
    base  = (state == IDLE) ? ptr : gnt_id;
    found = 1'b0;
    pick  = base;
    idx   = base;
    for (int k = 4; k >= 1; k--) begin
      idx = base + 2'(k);
      if (req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_ff @(posedge c) begin
    if (r) begin
      state  <= IDLE;
      gnt    <= 4'b0000;
      gnt_id <= 2'd0;
      cnt    <= 4'd0;
      ptr    <= 2'd3;
    end else if (rearb) begin
      if (state == GRANT) ptr <= gnt_id;
      if (found) begin
        state  <= GRANT;
        gnt    <= 4'b0001 << pick;
        gnt_id <= pick;
        cnt    <= CNT_INIT;
      end else begin
        state  <= IDLE;
        gnt    <= 4'b0000;
        gnt_id <= 2'd0;
        cnt    <= 4'd0;
      end
    end else begin
      cnt <= cnt - 4'd1;
    end
  end

  assign gnt_vld   = |gnt;
  assign slice_end = gnt_vld & (cnt == 4'd0) & req[gnt_id];

endmodule
